// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared pipeline constants for the ID/EX hazard and forwarding control.
// Holds the EX operand-mux select encoding and register-address defaults.
package hazard_forward_ctrl_pkg;

    localparam int DEF_ADDR_W = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    // EX-stage 3:1 operand mux select
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline tag slot {reg_write, mem_read, dst} with bubble insert.
// Ports: clk, reset (sync, high), bubble (load zeros), d (next tag), q (tag).
module stage_tag_reg
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int W = DEF_ADDR_W + 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // An all-zero tag is a NOP: no write, no load, dst = $zero.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// ID/EX hazard control: tracks EX/MEM/WB tags, registers forward selects,
// detects load-use stalls and inserts EX bubbles on stall or flush.
// Ports: clk, reset, id_* (ID instruction fields), flush; fwd_a/fwd_b,
// stall, pc_write_en, ifid_write_en, idex_bubble.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              idex_bubble
);

    localparam int TW = ADDR_W + 2;
    localparam int RW = TW - 1;
    localparam int MR = TW - 2;

    logic [TW-1:0] id_tag;
    logic [TW-1:0] ex_tag;
    logic [TW-1:0] mem_tag;
    logic [TW-1:0] wb_tag;
    logic [1:0]    cnt;
    logic          ex_rs;
    logic          ex_rt;
    logic          mem_rs;
    logic          mem_rt;
    logic          hazard;
    logic          unused_tags;

    function automatic logic hit(
        input logic [TW-1:0]     t,
        input logic [ADDR_W-1:0] r,
        input logic              used
    );
        return t[RW] && used &&
               (t[ADDR_W-1:0] != ADDR_W'(REG_ZERO)) &&
               (t[ADDR_W-1:0] == r);
    endfunction

    function automatic logic [1:0] pick(
        input logic ex_hit,
        input logic mem_hit
    );
        // the newer producer wins
        if (ex_hit) begin
            return FWD_MEM;
        end else if (mem_hit) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    assign id_tag = {id_reg_write, id_mem_read, id_dst};

    stage_tag_reg #(.W(TW)) u_ex (
        .clk    (clk),
        .reset  (reset),
        .bubble (idex_bubble),
        .d      (id_tag),
        .q      (ex_tag)
    );

    stage_tag_reg #(.W(TW)) u_mem (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (ex_tag),
        .q      (mem_tag)
    );

    stage_tag_reg #(.W(TW)) u_wb (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (mem_tag),
        .q      (wb_tag)
    );

    // WB is covered by regfile write-before-read, so it is tracked only.
    assign unused_tags = ^{wb_tag, mem_tag[MR]};

    // Matches are evaluated one stage early: EX now becomes MEM when the
    // ID instruction reaches EX, and MEM now becomes WB.
    assign ex_rs  = hit(ex_tag, id_rs, id_use_rs);
    assign ex_rt  = hit(ex_tag, id_rt, id_use_rt);
    assign mem_rs = hit(mem_tag, id_rs, id_use_rs);
    assign mem_rt = hit(mem_tag, id_rt, id_use_rt);

    assign hazard = ex_tag[MR] && (ex_rs || ex_rt);

    // Reset and flush both override any pending stall.
    assign stall = !reset && !flush &&
                   ((hazard && cnt == 2'd0) || cnt != 2'd0);

    assign pc_write_en   = !stall;
    assign ifid_write_en = !stall;
    assign idex_bubble   = stall || flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cnt <= 2'd0;
        end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end else if (hazard) begin
            cnt <= 2'(LOAD_STALL - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || idex_bubble) begin
            fwd_a <= FWD_REG;
            fwd_b <= FWD_REG;
        end else begin
            fwd_a <= pick(ex_rs, mem_rs);
            fwd_b <= pick(ex_rt, mem_rt);
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl with LOAD_STALL = 1 and 3.
// Both instances share stimulus; expectations are hand-computed per cycle.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic [4:0] id_dst = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       flush = 1'b0;

    logic [1:0] fa1, fb1, fa3, fb3;
    logic       st1, pc1, if1, bb1;
    logic       st3, pc3, if3, bb3;

    typedef struct {
        string      name;
        logic       fl;
        logic [1:0] fa1;
        logic [1:0] fb1;
        logic       st1;
        logic [1:0] fa3;
        logic [1:0] fb3;
        logic       st3;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.ADDR_W(5), .LOAD_STALL(1)) u1 (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_dst        (id_dst),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .flush         (flush),
        .fwd_a         (fa1),
        .fwd_b         (fb1),
        .stall         (st1),
        .pc_write_en   (pc1),
        .ifid_write_en (if1),
        .idex_bubble   (bb1)
    );

    hazard_forward_ctrl #(.ADDR_W(5), .LOAD_STALL(3)) u3 (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_dst        (id_dst),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .flush         (flush),
        .fwd_a         (fa3),
        .fwd_b         (fb3),
        .stall         (st3),
        .pc_write_en   (pc3),
        .ifid_write_en (if3),
        .idex_bubble   (bb3)
    );

    // Drive one ID instruction for a cycle and queue what both DUTs
    // should show during that cycle.
    task automatic step(
        input string n,
        input logic r, input logic f,
        input int rs, input int rt,
        input logic urs, input logic urt,
        input int dst, input logic rw, input logic mr,
        input logic [1:0] ea1, input logic [1:0] eb1, input logic es1,
        input logic [1:0] ea3, input logic [1:0] eb3, input logic es3
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset        = r;
        flush        = f;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_dst       = 5'(dst);
        id_reg_write = rw;
        id_mem_read  = mr;
        e.name = n;
        e.fl   = f;
        e.fa1  = ea1;
        e.fb1  = eb1;
        e.st1  = es1;
        e.fa3  = ea3;
        e.fb3  = eb3;
        e.st3  = es3;
        sb.push_back(e);
    endtask

    task automatic nop(input string n, input logic r,
                       input logic [1:0] ea, input logic [1:0] eb);
        step(n, r, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0, ea, eb, 0);
    endtask

    // Monitor: pops one expectation per cycle, mid-cycle.
    initial begin
        exp_t e;
        logic [5:0] got;
        logic [5:0] want;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                want = {e.fa1, e.fb1, e.st1, !e.st1, !e.st1, e.st1 | e.fl};
                got  = {fa1, fb1, st1, pc1, if1, bb1};
                n_vec++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL %s ls1 {fa,fb,st,pc,ifid,bub} got %b want %b",
                             e.name, got, want);
                end
                want = {e.fa3, e.fb3, e.st3, !e.st3, !e.st3, e.st3 | e.fl};
                got  = {fa3, fb3, st3, pc3, if3, bb3};
                n_vec++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL %s ls3 {fa,fb,st,pc,ifid,bub} got %b want %b",
                             e.name, got, want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // back-to-back, distance 2, double producer, $zero
        nop ("rst",       1, 2'b00, 2'b00);
        step("add3",      0, 0, 1, 2, 1, 1, 3, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("sub4_3_5",  0, 0, 3, 5, 1, 1, 4, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        nop ("b2b_ex",    0, 2'b10, 2'b00);
        step("add3_d2",   0, 0, 1, 2, 1, 1, 3, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        nop ("d2_nop",    0, 2'b00, 2'b00);
        step("or6_3_3",   0, 0, 3, 3, 1, 1, 6, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        nop ("d2_ex",     0, 2'b01, 2'b01);
        step("add3_a",    0, 0, 1, 2, 1, 1, 3, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("add3_b",    0, 0, 1, 2, 1, 1, 3, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("and7_3_0",  0, 0, 3, 0, 1, 1, 7, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        nop ("dbl_ex",    0, 2'b10, 2'b00);
        step("add0",      0, 0, 1, 2, 1, 1, 0, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("add4_0_0",  0, 0, 0, 0, 1, 1, 4, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("lw0",       0, 0, 1, 0, 1, 0, 0, 1, 1,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("use0",      0, 0, 0, 0, 1, 1, 5, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        nop ("zero_ex",   0, 2'b00, 2'b00);

        // load-use: one stall for LS=1, three for LS=3
        nop ("lu_rst",    1, 2'b00, 2'b00);
        step("lw8",       0, 0, 1, 0, 1, 0, 8, 1, 1,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("lu_c0",     0, 0, 8, 1, 1, 1, 9, 1, 0,
             2'b00, 2'b00, 1, 2'b00, 2'b00, 1);
        step("lu_c1",     0, 0, 8, 1, 1, 1, 9, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 1);
        step("lu_c2",     0, 0, 8, 1, 1, 1, 9, 1, 0,
             2'b01, 2'b00, 0, 2'b00, 2'b00, 1);
        step("lu_c3",     0, 0, 8, 1, 1, 1, 9, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        nop ("lu_end",    0, 2'b00, 2'b00);

        // flush inside the stall window
        nop ("fl_rst",    1, 2'b00, 2'b00);
        step("fl_lw8",    0, 0, 1, 0, 1, 0, 8, 1, 1,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("fl_c0",     0, 0, 8, 1, 1, 1, 9, 1, 0,
             2'b00, 2'b00, 1, 2'b00, 2'b00, 1);
        step("fl_c1",     0, 1, 8, 1, 1, 1, 9, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        nop ("fl_after",  0, 2'b00, 2'b00);

        // reset inside the stall window
        nop ("rs_rst",    1, 2'b00, 2'b00);
        step("rs_lw8",    0, 0, 1, 0, 1, 0, 8, 1, 1,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("rs_c0",     0, 0, 8, 1, 1, 1, 9, 1, 0,
             2'b00, 2'b00, 1, 2'b00, 2'b00, 1);
        step("rs_c1",     1, 0, 8, 1, 1, 1, 9, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        step("rs_after",  0, 0, 8, 1, 1, 1, 9, 1, 0,
             2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        nop ("rs_end",    0, 2'b00, 2'b00);

        @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain left %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline control block between ID and EX of the 5-stage 32-bit datapath.
- Tracks destination register, register-write and load flags of instructions in EX, MEM and WB.
- Produces the registered 2-bit operand-forward selects that drive the EX-stage 3:1 operand muxes.
- Detects load-use hazards, stalls PC and IF/ID with a cycle counter, and inserts bubbles into EX on stall or branch flush.

Parameters:
- ADDR_W, 5: register address width.
- LOAD_STALL, 1: bubble cycles inserted per load-use hazard (legal range 1..3).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_rs  input  ADDR_W  source register A of the instruction in ID.
- id_rt  input  ADDR_W  source register B of the instruction in ID.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_dst  input  ADDR_W  destination register of the ID instruction (post rd/rt select).
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch/jump resolved taken in EX; squash the ID instruction.
- fwd_a  output  2  EX operand-A select: 00 = regfile, 01 = WB result, 10 = MEM ALU result.
- fwd_b  output  2  EX operand-B select, same encoding as fwd_a.
- stall  output  1  load-use stall active (combinational).
- pc_write_en  output  1  equals ~stall.
- ifid_write_en  output  1  equals ~stall.
- idex_bubble  output  1  equals stall | flush; ID/EX loads a NOP.

Behaviour:
- Reset, synchronous:
  - ex/mem/wb reg_write and ex mem_read cleared; all dst fields 0.
  - fwd_a = fwd_b = 00; stall counter 0.
  - Outputs in reset cycle: stall = 0, pc_write_en = 1, ifid_write_en = 1, idex_bubble = flush.
- Tracking shift, every non-reset cycle:
  - wb <= mem; mem <= ex.
  - ex <= ID fields, or a bubble (reg_write = 0, mem_read = 0, dst = 0) when idex_bubble.
- Hazard match: "X matches r" means X.reg_write & X.dst != 0 & X.dst == r & r is used. Register 0 never matches.
- Load-use detect:
  - hazard = ex.mem_read & (ex matches id_rs | ex matches id_rt).
  - stall = (hazard & cnt == 0) | (cnt != 0).
- Stall counter:
  - On hazard with cnt == 0, load cnt = LOAD_STALL - 1 (stall asserted this cycle).
  - While cnt != 0, decrement each cycle with stall held.
  - With LOAD_STALL = 1, exactly one stall cycle.
- Forward selects, registered and valid while the instruction sits in EX:
  - fwd_a <= 00 if idex_bubble.
  - Otherwise 10 if ex matches id_rs; else 01 if mem matches id_rs; else 00.
  - fwd_b is identical using id_rt.
  - The newer producer (MEM) wins over WB.
- Flush priority:
  - flush forces stall = 0 and clears cnt in the same cycle.
  - flush asserted mid-stall aborts the stall.
- Producers older than WB are not forwarded; the register file write-before-read covers them.
- Reset asserted mid-stall clears cnt at that edge; stall is 0 the following cycle.

Decomposition:
- Shared pipeline package holds:
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10 (the EX 3:1 mux select encoding).
  - ADDR_W default and the REG_ZERO constant.
- One natural sub-module: stage_tag_reg, one ADDR_W+2-bit stage slot with bubble insert, instantiated for EX/MEM/WB.

Test Plan:
- Back-to-back ALU: add $3,$1,$2 then sub $4,$3,$5 → second instruction in EX with fwd_a = 10, fwd_b = 00, stall never asserted.
- Distance 2: add $3 ... ; nop ; or $6,$3,$3 → or in EX with fwd_a = fwd_b = 01.
- Double producer: add $3 ; add $3 ; and $7,$3,$0 → fwd_a = 10 (MEM wins), fwd_b = 00.
- Load-use, LOAD_STALL = 1: lw $8 ; add $9,$8,$1 → stall = 1, pc_write_en = 0, idex_bubble = 1 for one cycle; add then in EX with fwd_a = 01. With LOAD_STALL = 3 → exactly 3 stall cycles.
- $zero: add $0,$1,$2 then add $4,$0,$0 → fwd_a = fwd_b = 00; lw $0 followed by a use of $0 → no stall.
- Flush during stall, and reset during stall:
  - flush asserted in the stall cycle → stall = 0 and idex_bubble = 1 that cycle, fwd outputs 00 next cycle.
  - reset asserted during a LOAD_STALL = 3 stall → stall = 0 and fwd = 00 after the edge.
